qubit_coord_table: RTL and testbench
====================================

# qubit_coord_table

Runtime-programmable qubit coordinate table: the parametrised successor of the fixed-grid qubit lookup. After reset it fills itself with a rectangular grid. It then accepts per-qubit coordinate overwrites, global drift offsets and grid regeneration with new origin/spacing. It drives registered parallel X/Y/enable arrays to `coord_matcher` and the tweezer path.

## Interface
Parameters:
- `NUM_QUBITS`, 100, table depth
- `GRID_COLS`, 10, columns per grid row
- `COORD_WIDTH`, 10, unsigned coordinate width
- `DEF_START_X`, 100, reset-grid origin X
- `DEF_START_Y`, 100, reset-grid origin Y
- `DEF_SPACING`, 20, reset-grid pitch

Ports (`IDX_W = $clog2(NUM_QUBITS)`):
- `i_clk` in 1: clock; one clock domain.
- `i_rst` in 1: reset; synchronous, active-high.
- `i_wr_valid` in 1: single-entry write request.
- `i_wr_idx` in IDX_W: entry to write.
- `i_wr_x`, `i_wr_y` in COORD_WIDTH: new coordinates.
- `i_wr_en` in 1: new enable bit for the entry.
- `o_wr_ready` in/out: out 1; high only in IDLE.
- `i_off_valid` in 1: apply a global offset.
- `i_off_dx`, `i_off_dy` in COORD_WIDTH+1: signed two's-complement offset.
- `i_regen` in 1: rebuild the grid from the runtime origin and pitch.
- `i_start_x`, `i_start_y`, `i_spacing` in COORD_WIDTH: runtime grid origin and pitch, sampled on `i_regen`.
- `o_q_x`, `o_q_y` out [COORD_WIDTH] x NUM_QUBITS: coordinate arrays.
- `o_q_en` out NUM_QUBITS: per-qubit enable.
- `o_table_valid` out 1: table complete and consistent.
- `o_busy` out 1: INIT in progress.
- `o_err` out 1: one-cycle pulse on a dropped request.

## Operation
- FSM states: INIT, IDLE.
- Reset:
  - State goes to INIT.
  - Grid parameters load from the `DEF_*` parameters.
  - All `o_q_x`, `o_q_y` and `o_q_en` entries clear to 0.
  - `o_table_valid`=0, `o_busy`=1, `o_err`=0, `o_wr_ready`=0.
- INIT:
  - Writes one entry per cycle, starting at idx 0.
  - Each entry gets x = start_x + col·spacing, y = start_y + row·spacing, en = 1.
  - col and row are incremental counters. col wraps at GRID_COLS−1, and row increments on that wrap. No divide or modulo.
  - After writing idx NUM_QUBITS−1 the FSM goes to IDLE. In the same cycle `o_table_valid`=1 and `o_busy`=0.
  - Grid arithmetic is computed at COORD_WIDTH+1 bits and saturates at 2^COORD_WIDTH−1.
- IDLE, write (`i_wr_valid` & `o_wr_ready`):
  - If idx < NUM_QUBITS: the entry takes the write values.
  - If idx ≥ NUM_QUBITS: the write is dropped and `o_err` pulses.
- IDLE, offset (`i_off_valid`):
  - Every entry updates as coord ← clamp(coord + d, 0, 2^COORD_WIDTH−1).
  - Enable bits are unchanged.
- IDLE, regen (`i_regen`):
  - Latches `i_start_x`, `i_start_y` and `i_spacing`.
  - Clears `o_table_valid` and enters INIT next cycle; all enables are rebuilt to 1.
- Simultaneous events in IDLE:
  - regen + anything: regen wins. The write and offset are dropped and `o_err` pulses.
  - write + offset: the offset applies to all entries, then the write overrides the addressed entry. The written value is stored unoffset.
- Requests during INIT:
  - Writes are not accepted (ready=0), so no error.
  - `i_off_valid` and `i_regen` are dropped with an `o_err` pulse.
- Reset mid-INIT or mid-operation: unconditional restart as in reset.

## Timing
- All outputs are registered.
- Write and offset effects are visible on the outputs the cycle after acceptance (latency 1).
- INIT takes exactly NUM_QUBITS cycles.
  - After reset deasserts on edge k: `o_table_valid` rises at edge k+NUM_QUBITS.
  - For regen sampled at edge k: valid falls at k+1 and rises at k+1+NUM_QUBITS.
- `o_wr_ready` is a registered copy of (state==IDLE) and does not depend on `i_wr_valid`.
- `o_err` is high for exactly one cycle per offending cycle.

## Structure
- `params_pkg` holds:
  - `NUM_QUBITS`, `GRID_COLS`, `COORD_WIDTH`.
  - `QUBIT_START_X/Y` and `QUBIT_SPACING`, used as the `DEF_*` defaults.
  - New `typedef enum logic {CT_INIT, CT_IDLE} coord_tbl_state_e`.
  - New function `sat_add_coord(coord, signed delta)`.
- Sub-module `coord_sat_adder`: combinational clamp adder, instantiated once per axis per entry through a generate loop.

## Test plan
- Reset with defaults:
  - `o_table_valid` rises exactly 100 cycles after reset release.
  - Entry 0 = (100,100), entry 9 = (280,100), entry 10 = (100,120), entry 99 = (280,280).
  - All enables = 1.
- Write idx 37 = (500,611, en=0): next cycle entry 37 = (500,611, en 0) and its neighbours are unchanged. A write to idx 100 pulses `o_err` and changes nothing.
- Offset dx=−150, dy=+800:
  - Entry 0 becomes (0,900). X clamps at 0; y is not clamped because 100+800=900 < 1023.
  - A second dy=+200 clamps all y to 1023.
- Same-cycle write idx 5 = (50,50) plus offset dx=+10, dy=+10: entry 5 = (50,50) and entry 6 = (230,110).
- Regen with start (0,0), spacing 30:
  - `o_busy` is high for 100 cycles; writes are refused (`o_wr_ready`=0) and an offset during INIT pulses `o_err`.
  - Final entry 99 = (270,270).
- Assert `i_rst` at INIT cycle 50 of a regen: the table clears and rebuilds with the default grid.

Source files
------------

// File: rtl/qubit_coord_table_pkg.sv
// Shared constants, FSM state type and the scalar clamp helper for the
// qubit coordinate table.
package qubit_coord_table_pkg;

  localparam int NUM_QUBITS    = 100;
  localparam int GRID_COLS     = 10;
  localparam int COORD_WIDTH   = 10;
  localparam int QUBIT_START_X = 100;
  localparam int QUBIT_START_Y = 100;
  localparam int QUBIT_SPACING = 20;

  typedef enum logic {
    CT_INIT = 1'b0,
    CT_IDLE = 1'b1
  } coord_tbl_state_e;

  // coord + delta, clamped to [0, 2^COORD_WIDTH-1]; two guard bits keep
  // both the negative and the overflow case visible in the sum.
  function automatic logic [COORD_WIDTH-1:0] sat_add_coord(
    input logic        [COORD_WIDTH-1:0] coord,
    input logic signed [COORD_WIDTH:0]   delta
  );
    logic signed [COORD_WIDTH+1:0] sum;
    sum = $signed({2'b00, coord}) + $signed({delta[COORD_WIDTH], delta});
    if (sum[COORD_WIDTH+1]) begin
      sat_add_coord = '0;
    end else if (sum[COORD_WIDTH]) begin
      sat_add_coord = '1;
    end else begin
      sat_add_coord = sum[COORD_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/qubit_coord_table_if.sv
// Request/response bundle of the qubit coordinate table. The master drives
// write/offset/regen requests; the slave (the table) drives the arrays.
interface qubit_coord_table_if #(
  parameter int NUM_QUBITS  = 100,
  parameter int COORD_WIDTH = 10,
  parameter int IDX_W       = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1
);

  logic                                   i_wr_valid;
  logic [IDX_W-1:0]                       i_wr_idx;
  logic [COORD_WIDTH-1:0]                 i_wr_x;
  logic [COORD_WIDTH-1:0]                 i_wr_y;
  logic                                   i_wr_en;
  logic                                   o_wr_ready;
  logic                                   i_off_valid;
  logic signed [COORD_WIDTH:0]            i_off_dx;
  logic signed [COORD_WIDTH:0]            i_off_dy;
  logic                                   i_regen;
  logic [COORD_WIDTH-1:0]                 i_start_x;
  logic [COORD_WIDTH-1:0]                 i_start_y;
  logic [COORD_WIDTH-1:0]                 i_spacing;
  logic [NUM_QUBITS-1:0][COORD_WIDTH-1:0] o_q_x;
  logic [NUM_QUBITS-1:0][COORD_WIDTH-1:0] o_q_y;
  logic [NUM_QUBITS-1:0]                  o_q_en;
  logic                                   o_table_valid;
  logic                                   o_busy;
  logic                                   o_err;

  modport master (
    output i_wr_valid, i_wr_idx, i_wr_x, i_wr_y, i_wr_en,
    output i_off_valid, i_off_dx, i_off_dy,
    output i_regen, i_start_x, i_start_y, i_spacing,
    input  o_wr_ready, o_q_x, o_q_y, o_q_en, o_table_valid, o_busy, o_err
  );

  modport slave (
    input  i_wr_valid, i_wr_idx, i_wr_x, i_wr_y, i_wr_en,
    input  i_off_valid, i_off_dx, i_off_dy,
    input  i_regen, i_start_x, i_start_y, i_spacing,
    output o_wr_ready, o_q_x, o_q_y, o_q_en, o_table_valid, o_busy, o_err
  );

endinterface

// File: rtl/qubit_coord_table_sat.sv
// Combinational clamp adder: unsigned coordinate plus signed delta, clamped
// to the representable coordinate range.
module coord_sat_adder #(
  parameter int CW = 10
) (
  input  logic        [CW-1:0] coord_i,
  input  logic signed [CW:0]   delta_i,
  output logic        [CW-1:0] sum_o
);

  logic signed [CW+1:0] sum_s;

  // Wide signed sum, then clamp below at 0 and above at all-ones.
  always_comb begin
    sum_s = $signed({2'b00, coord_i}) + $signed({delta_i[CW], delta_i});
    if (sum_s[CW+1]) begin
      sum_o = '0;
    end else if (sum_s[CW]) begin
      sum_o = '1;
    end else begin
      sum_o = sum_s[CW-1:0];
    end
  end

endmodule

// File: rtl/qubit_coord_table.sv
// Runtime-programmable qubit coordinate table. Builds a rectangular grid one
// entry per cycle (INIT), then serves single-entry writes, global clamped
// offsets and grid regeneration (IDLE). All outputs are registered.
module qubit_coord_table #(
  parameter int NUM_QUBITS  = qubit_coord_table_pkg::NUM_QUBITS,
  parameter int GRID_COLS   = qubit_coord_table_pkg::GRID_COLS,
  parameter int COORD_WIDTH = qubit_coord_table_pkg::COORD_WIDTH,
  parameter int DEF_START_X = qubit_coord_table_pkg::QUBIT_START_X,
  parameter int DEF_START_Y = qubit_coord_table_pkg::QUBIT_START_Y,
  parameter int DEF_SPACING = qubit_coord_table_pkg::QUBIT_SPACING
) (
  input logic               i_clk,
  input logic               i_rst,
  qubit_coord_table_if.slave bus
);

  import qubit_coord_table_pkg::*;

  localparam int IDX_W = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1;
  localparam int COL_W = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_QUBITS - 1);
  localparam logic [COL_W-1:0]       LAST_COL = COL_W'(GRID_COLS - 1);
  localparam logic [IDX_W:0]         DEPTH    = (IDX_W + 1)'(NUM_QUBITS);
  localparam logic [COORD_WIDTH-1:0] DEF_X    = COORD_WIDTH'(DEF_START_X);
  localparam logic [COORD_WIDTH-1:0] DEF_Y    = COORD_WIDTH'(DEF_START_Y);
  localparam logic [COORD_WIDTH-1:0] DEF_SP   = COORD_WIDTH'(DEF_SPACING);

  coord_tbl_state_e state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [COL_W-1:0]       col_q, col_d;
  // Running grid coordinates of the entry being built: cur_x restarts at
  // the origin on each column wrap, cur_y acts as the row accumulator.
  logic [COORD_WIDTH-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [COORD_WIDTH-1:0] start_x_q, start_x_d, start_y_q, start_y_d;
  logic [COORD_WIDTH-1:0] spacing_q, spacing_d;
  logic [NUM_QUBITS-1:0][COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [NUM_QUBITS-1:0]  en_q, en_d;
  logic                   valid_q, valid_d, busy_q, busy_d;
  logic                   err_q, err_d, ready_q, ready_d;

  logic                   wr_fire_s, wr_in_range_s;
  logic signed [COORD_WIDTH:0] spacing_delta_s;
  logic [COORD_WIDTH-1:0] step_x_s, step_y_s;
  logic [NUM_QUBITS-1:0][COORD_WIDTH-1:0] off_x_s, off_y_s;

  assign wr_fire_s       = bus.i_wr_valid & ready_q;
  assign wr_in_range_s   = ({1'b0, bus.i_wr_idx} < DEPTH);
  assign spacing_delta_s = $signed({1'b0, spacing_q});

  // Grid stepping: one pitch added per column / row, saturating.
  coord_sat_adder #(.CW(COORD_WIDTH)) u_step_x (
    .coord_i(cur_x_q), .delta_i(spacing_delta_s), .sum_o(step_x_s)
  );
  coord_sat_adder #(.CW(COORD_WIDTH)) u_step_y (
    .coord_i(cur_y_q), .delta_i(spacing_delta_s), .sum_o(step_y_s)
  );

  // Offset candidates for every entry, used only when an offset is taken.
  for (genvar g = 0; g < NUM_QUBITS; g++) begin : g_off
    coord_sat_adder #(.CW(COORD_WIDTH)) u_off_x (
      .coord_i(x_q[g]), .delta_i(bus.i_off_dx), .sum_o(off_x_s[g])
    );
    coord_sat_adder #(.CW(COORD_WIDTH)) u_off_y (
      .coord_i(y_q[g]), .delta_i(bus.i_off_dy), .sum_o(off_y_s[g])
    );
  end

  // Next-state and table update: grid build in INIT, requests in IDLE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    col_d     = col_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    start_x_d = start_x_q;
    start_y_d = start_y_q;
    spacing_d = spacing_q;
    x_d       = x_q;
    y_d       = y_q;
    en_d      = en_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    case (state_q)
      CT_INIT: begin
        x_d[idx_q]  = cur_x_q;
        y_d[idx_q]  = cur_y_q;
        en_d[idx_q] = 1'b1;
        if (col_q == LAST_COL) begin
          col_d   = '0;
          cur_x_d = start_x_q;
          cur_y_d = step_y_s;
        end else begin
          col_d   = col_q + COL_W'(1);
          cur_x_d = step_x_s;
        end
        if (idx_q == LAST_IDX) begin
          state_d = CT_IDLE;
          idx_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
        // Writes are held off by ready=0; offset/regen are dropped loudly.
        err_d = bus.i_off_valid | bus.i_regen;
      end
      CT_IDLE: begin
        if (bus.i_regen) begin
          state_d   = CT_INIT;
          idx_d     = '0;
          col_d     = '0;
          start_x_d = bus.i_start_x;
          start_y_d = bus.i_start_y;
          spacing_d = bus.i_spacing;
          cur_x_d   = bus.i_start_x;
          cur_y_d   = bus.i_start_y;
          valid_d   = 1'b0;
          busy_d    = 1'b1;
          err_d     = wr_fire_s | bus.i_off_valid;
        end else begin
          if (bus.i_off_valid) begin
            x_d = off_x_s;
            y_d = off_y_s;
          end else begin
            x_d = x_q;
            y_d = y_q;
          end
          // The write lands after the offset, so its value is stored unoffset.
          if (wr_fire_s) begin
            if (wr_in_range_s) begin
              x_d[bus.i_wr_idx]  = bus.i_wr_x;
              y_d[bus.i_wr_idx]  = bus.i_wr_y;
              en_d[bus.i_wr_idx] = bus.i_wr_en;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            err_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = CT_INIT;
      end
    endcase
    ready_d = (state_d == CT_IDLE);
  end

  // State and table registers; reset restarts the default grid build.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= CT_INIT;
      idx_q     <= '0;
      col_q     <= '0;
      cur_x_q   <= DEF_X;
      cur_y_q   <= DEF_Y;
      start_x_q <= DEF_X;
      start_y_q <= DEF_Y;
      spacing_q <= DEF_SP;
      x_q       <= '0;
      y_q       <= '0;
      en_q      <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b1;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      col_q     <= col_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      start_x_q <= start_x_d;
      start_y_q <= start_y_d;
      spacing_q <= spacing_d;
      x_q       <= x_d;
      y_q       <= y_d;
      en_q      <= en_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.o_q_x         = x_q;
  assign bus.o_q_y         = y_q;
  assign bus.o_q_en        = en_q;
  assign bus.o_table_valid = valid_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_err         = err_q;
  assign bus.o_wr_ready    = ready_q;

endmodule

// File: tb/tb_qubit_coord_table.sv
// Scoreboard bench for qubit_coord_table: stimulus schedules expected
// observations per cycle, a monitor compares them on the falling edge.
module tb_qubit_coord_table;

  localparam int NQ = 100;
  localparam int CW = 10;

  localparam int K_ENTRY = 0;
  localparam int K_VALID = 1;
  localparam int K_BUSY  = 2;
  localparam int K_ERR   = 3;
  localparam int K_READY = 4;
  localparam int K_ALLEN = 5;
  localparam int K_ALLY  = 6;

  typedef struct {
    int    cyc;
    int    kind;
    int    idx;
    int    x;
    int    y;
    int    en;
    string name;
  } chk_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  chk_t sb_q[$];

  qubit_coord_table_if #(.NUM_QUBITS(NQ), .COORD_WIDTH(CW)) bus ();

  qubit_coord_table #(
    .NUM_QUBITS(NQ), .GRID_COLS(10), .COORD_WIDTH(CW),
    .DEF_START_X(100), .DEF_START_Y(100), .DEF_SPACING(20)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  function automatic void push(int at, int kind, int idx, int x, int y, int en, string name);
    chk_t c;
    int   pos;
    c.cyc = at; c.kind = kind; c.idx = idx; c.x = x; c.y = y; c.en = en; c.name = name;
    pos = sb_q.size();
    while (pos > 0 && sb_q[pos-1].cyc > at) pos--;
    sb_q.insert(pos, c);
  endfunction

  function automatic void pe(int at, int idx, int x, int y, int en);
    push(at, K_ENTRY, idx, x, y, en, "entry");
  endfunction

  function automatic void ps(int at, int kind, int val, string name);
    push(at, kind, 0, val, 0, 0, name);
  endfunction

  function automatic void check_item(chk_t c);
    int ax, ay, ae, act;
    checks = checks + 1;
    if (c.cyc != cyc) begin
      errors = errors + 1;
      $display("FAIL %s late: checked at cycle %0d, scheduled %0d", c.name, cyc, c.cyc);
    end else if (c.kind == K_ENTRY) begin
      ax = int'(bus.o_q_x[c.idx]);
      ay = int'(bus.o_q_y[c.idx]);
      ae = int'(bus.o_q_en[c.idx]);
      if (ax != c.x || ay != c.y || ae != c.en) begin
        errors = errors + 1;
        $display("FAIL %s[%0d] cyc %0d: got (%0d,%0d,en=%0d) want (%0d,%0d,en=%0d)",
                 c.name, c.idx, cyc, ax, ay, ae, c.x, c.y, c.en);
      end
    end else if (c.kind == K_ALLY) begin
      act = 0;
      for (int i = 0; i < NQ; i++) if (int'(bus.o_q_y[i]) != c.x) act = act + 1;
      if (act != 0) begin
        errors = errors + 1;
        $display("FAIL %s cyc %0d: %0d entries differ from y=%0d", c.name, cyc, act, c.x);
      end
    end else begin
      case (c.kind)
        K_VALID: act = int'(bus.o_table_valid);
        K_BUSY:  act = int'(bus.o_busy);
        K_ERR:   act = int'(bus.o_err);
        K_READY: act = int'(bus.o_wr_ready);
        K_ALLEN: act = (bus.o_q_en == {NQ{1'b1}}) ? 1 : 0;
        default: act = -1;
      endcase
      if (act != c.x) begin
        errors = errors + 1;
        $display("FAIL %s cyc %0d: got %0d want %0d", c.name, cyc, act, c.x);
      end
    end
  endfunction

  // Monitor: compare every scheduled observation on the falling edge.
  initial begin
    chk_t c;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        c = sb_q.pop_front();
        check_item(c);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) step();
  endtask

  task automatic idle_inputs();
    bus.i_wr_valid  = 1'b0;
    bus.i_wr_idx    = '0;
    bus.i_wr_x      = '0;
    bus.i_wr_y      = '0;
    bus.i_wr_en     = 1'b0;
    bus.i_off_valid = 1'b0;
    bus.i_off_dx    = '0;
    bus.i_off_dy    = '0;
    bus.i_regen     = 1'b0;
    bus.i_start_x   = '0;
    bus.i_start_y   = '0;
    bus.i_spacing   = '0;
  endtask

  task automatic regen(int sx, int sy, int sp);
    bus.i_regen   = 1'b1;
    bus.i_start_x = CW'(sx);
    bus.i_start_y = CW'(sy);
    bus.i_spacing = CW'(sp);
  endtask

  initial begin
    int k;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_inputs();

    // Reset state and default grid build
    step(); step(); step();
    k = cyc;
    ps(k, K_VALID, 0, "rst_valid"); ps(k, K_BUSY, 1, "rst_busy");
    ps(k, K_ERR, 0, "rst_err");     ps(k, K_READY, 0, "rst_ready");
    pe(k, 0, 0, 0, 0);              pe(k, 99, 0, 0, 0);
    rst = 1'b0;
    ps(k + 99, K_VALID, 0, "valid_early"); ps(k + 99, K_BUSY, 1, "busy_early");
    ps(k + 100, K_VALID, 1, "valid_rise"); ps(k + 100, K_BUSY, 0, "busy_fall");
    ps(k + 100, K_READY, 1, "ready_idle");
    wait_until(k + 100);
    pe(cyc, 0, 100, 100, 1);  pe(cyc, 9, 280, 100, 1);
    pe(cyc, 10, 100, 120, 1); pe(cyc, 99, 280, 280, 1);
    ps(cyc, K_ALLEN, 1, "all_en");

    // Single write, then out-of-range write
    bus.i_wr_valid = 1'b1; bus.i_wr_idx = 7'd37;
    bus.i_wr_x = 10'd500; bus.i_wr_y = 10'd611; bus.i_wr_en = 1'b0;
    pe(cyc + 1, 37, 500, 611, 0); pe(cyc + 1, 36, 220, 160, 1);
    pe(cyc + 1, 38, 260, 160, 1); ps(cyc + 1, K_ERR, 0, "wr_err");
    step();
    bus.i_wr_idx = 7'd100; bus.i_wr_x = 10'd1; bus.i_wr_y = 10'd1;
    ps(cyc + 1, K_ERR, 1, "oob_err"); pe(cyc + 1, 99, 280, 280, 1);
    pe(cyc + 1, 37, 500, 611, 0);
    step();
    bus.i_wr_valid = 1'b0;
    ps(cyc + 1, K_ERR, 0, "err_pulse_end");
    step();

    // Same-cycle write + offset: write value stored unoffset
    bus.i_wr_valid = 1'b1; bus.i_wr_idx = 7'd5;
    bus.i_wr_x = 10'd50; bus.i_wr_y = 10'd50; bus.i_wr_en = 1'b1;
    bus.i_off_valid = 1'b1; bus.i_off_dx = 11'sd10; bus.i_off_dy = 11'sd10;
    pe(cyc + 1, 5, 50, 50, 1);   pe(cyc + 1, 6, 230, 110, 1);
    pe(cyc + 1, 4, 190, 110, 1); pe(cyc + 1, 37, 510, 621, 0);
    step();
    idle_inputs();
    step();

    // Reset mid-operation, then clamped offsets on the fresh grid
    rst = 1'b1;
    step();
    k = cyc;
    pe(k, 0, 0, 0, 0); pe(k, 37, 0, 0, 0); ps(k, K_VALID, 0, "rst2_valid");
    rst = 1'b0;
    ps(k + 99, K_VALID, 0, "valid2_early"); ps(k + 100, K_VALID, 1, "valid2_rise");
    wait_until(k + 100);
    bus.i_off_valid = 1'b1; bus.i_off_dx = -11'sd150; bus.i_off_dy = 11'sd800;
    pe(cyc + 1, 0, 0, 900, 1);  pe(cyc + 1, 9, 130, 900, 1);
    pe(cyc + 1, 10, 0, 920, 1); pe(cyc + 1, 99, 130, 1023, 1);
    step();
    bus.i_off_dx = 11'sd0; bus.i_off_dy = 11'sd200;
    push(cyc + 1, K_ALLY, 0, 1023, 0, 0, "all_y_clamp");
    pe(cyc + 1, 0, 0, 1023, 1); pe(cyc + 1, 99, 130, 1023, 1);
    ps(cyc + 1, K_ALLEN, 1, "off_en_kept");
    step();
    idle_inputs();
    step();

    // Regen (0,0,30) with refused write and dropped offset during INIT
    regen(0, 0, 30);
    k = cyc + 1;
    ps(k, K_BUSY, 1, "regen_busy"); ps(k, K_VALID, 0, "regen_valid");
    ps(k, K_READY, 0, "regen_ready"); ps(k, K_ERR, 0, "regen_err");
    step();
    idle_inputs();
    wait_until(k + 3);
    bus.i_wr_valid = 1'b1; bus.i_wr_idx = 7'd50; bus.i_wr_x = 10'd7;
    bus.i_wr_y = 10'd7; bus.i_wr_en = 1'b0;
    bus.i_off_valid = 1'b1; bus.i_off_dx = 11'sd5; bus.i_off_dy = 11'sd5;
    ps(cyc + 1, K_ERR, 1, "init_off_err"); ps(cyc + 1, K_READY, 0, "init_ready");
    pe(cyc + 1, 2, 60, 0, 1); pe(cyc + 1, 1, 30, 0, 1);
    step();
    idle_inputs();
    ps(cyc + 1, K_ERR, 0, "init_err_end");
    ps(k + 99, K_BUSY, 1, "regen_busy_last"); ps(k + 99, K_VALID, 0, "regen_valid_early");
    ps(k + 100, K_VALID, 1, "regen_valid_rise"); ps(k + 100, K_BUSY, 0, "regen_busy_fall");
    ps(k + 100, K_READY, 1, "regen_ready_back");
    wait_until(k + 100);
    pe(cyc, 99, 270, 270, 1); pe(cyc, 0, 0, 0, 1);
    pe(cyc, 11, 30, 30, 1);   pe(cyc, 50, 0, 150, 1);
    ps(cyc, K_ALLEN, 1, "regen_all_en");
    step();

    // Regen near the top of the range: grid saturates
    regen(1000, 990, 20);
    k = cyc + 1;
    step();
    idle_inputs();
    wait_until(k + 100);
    pe(cyc, 0, 1000, 990, 1);  pe(cyc, 1, 1020, 990, 1);
    pe(cyc, 2, 1023, 990, 1);  pe(cyc, 10, 1000, 1010, 1);
    pe(cyc, 20, 1000, 1023, 1); pe(cyc, 99, 1023, 1023, 1);
    ps(cyc, K_VALID, 1, "sat_valid");
    step();

    // Regen colliding with write+offset, then reset at INIT cycle 50
    regen(0, 0, 30);
    bus.i_wr_valid = 1'b1; bus.i_wr_idx = 7'd3; bus.i_wr_x = 10'd5;
    bus.i_wr_y = 10'd5; bus.i_wr_en = 1'b1;
    bus.i_off_valid = 1'b1; bus.i_off_dx = 11'sd1; bus.i_off_dy = 11'sd1;
    k = cyc + 1;
    ps(k, K_ERR, 1, "regen_collide_err"); ps(k, K_VALID, 0, "collide_valid");
    pe(k, 3, 1023, 990, 1);
    step();
    idle_inputs();
    ps(cyc + 1, K_ERR, 0, "collide_err_end");
    wait_until(k + 50);
    rst = 1'b1;
    pe(cyc + 1, 0, 0, 0, 0); pe(cyc + 1, 99, 0, 0, 0);
    ps(cyc + 1, K_BUSY, 1, "midrst_busy"); ps(cyc + 1, K_READY, 0, "midrst_ready");
    step();
    rst = 1'b0;
    k = cyc;
    ps(k + 99, K_VALID, 0, "midrst_valid_early");
    ps(k + 100, K_VALID, 1, "midrst_valid_rise"); ps(k + 100, K_BUSY, 0, "midrst_busy_fall");
    wait_until(k + 100);
    pe(cyc, 0, 100, 100, 1); pe(cyc, 9, 280, 100, 1);
    pe(cyc, 10, 100, 120, 1); pe(cyc, 99, 280, 280, 1);
    step();
    step();

    while (sb_q.size() > 0) begin
      chk_t c;
      c = sb_q.pop_front();
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s never checked (scheduled cycle %0d)", c.name, c.cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
